mandelbrot_iterator: RTL

//   Per-pixel Mandelbrot escape-time engine, directly upstream of the iteration-to-colour LUT.

---
 rtl/mandelbrot_iterator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iterator.sv
// mandelbrot_iterator: escape-time engine for one complex point c, iterating z <- z^2 + c from z0 = 0.
// Build option MANDEL_MULT_PIPE_EN registers the squares/cross product (2 clocks per iteration).
module mandelbrot_iterator #(
   parameter int          WIDTH    = 18,
   parameter int          FRAC     = 14,
   parameter logic [11:0] MAX_ITER = 12'd1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] c_re,
   input  logic [WIDTH-1:0] c_im,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [11:0]      iterations,
   output logic [1:0]       state_dbg
);
   localparam int PW = 2 * WIDTH;
   localparam int SW = PW - FRAC;
   localparam logic signed [SW:0] ESC_LIM = (SW+1)'(64'sd4 <<< FRAC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
   logic signed [WIDTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
   logic [11:0]             n_q, n_d;
   logic [11:0]             iter_q, iter_d;

   logic signed [PW-1:0]    p_rr, p_ii, p_ri;
   logic signed [SW-1:0]    zr2_c, zi2_c, zri_c;
   logic signed [SW-1:0]    zr2, zi2, zri;
   logic signed [SW:0]      mag;
   logic signed [WIDTH-1:0] zr_next, zi_next;
   logic                    eval;

   // Squares of the current z; the SW-bit results hold the full range of z^2 >> FRAC.
   always_comb begin
      p_rr  = PW'(z_re_q) * PW'(z_re_q);
      p_ii  = PW'(z_im_q) * PW'(z_im_q);
      p_ri  = PW'(z_re_q) * PW'(z_im_q);
      zr2_c = SW'(p_rr >>> FRAC);
      zi2_c = SW'(p_ii >>> FRAC);
      zri_c = SW'(p_ri >>> FRAC);
   end

`ifdef MANDEL_MULT_PIPE_EN
   logic signed [SW-1:0] zr2_q, zi2_q, zri_q;
   logic                 phase_q, phase_d;

   // phase 0 captures the products of z_n, phase 1 tests/updates; z is stable across both.
   always_comb begin
      phase_d = (state_q == ST_ITER) ? ~phase_q : 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= 1'b0;
         zr2_q   <= '0;
         zi2_q   <= '0;
         zri_q   <= '0;
      end else begin
         phase_q <= phase_d;
         zr2_q   <= zr2_c;
         zi2_q   <= zi2_c;
         zri_q   <= zri_c;
      end
   end

   assign zr2  = zr2_q;
   assign zi2  = zi2_q;
   assign zri  = zri_q;
   assign eval = phase_q;
`else
   assign zr2  = zr2_c;
   assign zi2  = zi2_c;
   assign zri  = zri_c;
   assign eval = 1'b1;
`endif

   // The escape sum is one bit wider than the squares so it never wraps.
   always_comb begin
      mag     = (SW+1)'(zr2) + (SW+1)'(zi2);
      zr_next = WIDTH'(zr2) - WIDTH'(zi2) + c_re_q;
      zi_next = WIDTH'(zri <<< 1) + c_im_q;
   end

   // Handshake: start is accepted on any rising edge where ready=1 (IDLE or DONE);
   // c_re/c_im are sampled on that edge only. done pulses for exactly one cycle per
   // accepted point and iterations stays valid until the next accepted start.
   always_comb begin
      state_d = state_q;
      z_re_d  = z_re_q;
      z_im_d  = z_im_q;
      c_re_d  = c_re_q;
      c_im_d  = c_im_q;
      n_d     = n_q;
      iter_d  = iter_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               c_re_d  = c_re;
               c_im_d  = c_im;
               z_re_d  = '0;
               z_im_d  = '0;
               n_d     = '0;
               state_d = ST_ITER;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ITER: begin
            if (eval) begin
               if ((mag > ESC_LIM) || (n_q == MAX_ITER)) begin
                  iter_d  = n_q;
                  state_d = ST_DONE;
               end else begin
                  z_re_d = zr_next;
                  z_im_d = zi_next;
                  n_d    = n_q + 12'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         z_re_q  <= '0;
         z_im_q  <= '0;
         c_re_q  <= '0;
         c_im_q  <= '0;
         n_q     <= '0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         z_re_q  <= z_re_d;
         z_im_q  <= z_im_d;
         c_re_q  <= c_re_d;
         c_im_q  <= c_im_d;
         n_q     <= n_d;
         iter_q  <= iter_d;
      end
   end

   assign ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign busy       = (state_q == ST_ITER);
   assign done       = (state_q == ST_DONE);
   assign iterations = iter_q;
   assign state_dbg  = state_q;

endmodule
